rom_pipe: RTL

- Parametrised successor to the 16 KB registered-address instruction ROM.
- Byte-addressed, word-wide memory with a valid/ready request port and a valid/ready response port.
- Configurable depth, data width and an optional output register stage.
- Adds a write-only load port so the Pocket bridge can fill the program image at run time, plus error responses for misaligned or out-of-range addresses.

---
 rtl/rom_pipe.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rom_pipe.sv
// rom_pipe: byte-addressed word memory with a valid/ready read port, an optional
// output register stage, and a run-time load port for filling the program image.
module rom_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 4096,
    parameter int OUT_REG     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [31:0]           ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_err
);
    localparam int IDX_W   = $clog2(DEPTH_WORDS);
    localparam int BYTE_SH = $clog2(DATA_WIDTH / 8);
    localparam int HI_SH   = BYTE_SH + IDX_W;

    // Returns {err, idx}: err flags a misaligned or out-of-range byte address.
    function automatic logic [IDX_W:0] addr_decode(input logic [31:0] addr);
        logic bad;
        bad = (addr[BYTE_SH-1:0] != {BYTE_SH{1'b0}}) || ((addr >> HI_SH) != 32'd0);
        return {bad, addr[HI_SH-1:BYTE_SH]};
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];
    logic                  s1_valid_r;
    logic                  s1_err_r;
    logic [IDX_W-1:0]      s1_idx_r;
    logic [DATA_WIDTH-1:0] s1_data_s;
    logic                  s1_out_ok_s;
    logic                  stages_busy_s;
    logic [IDX_W:0]        req_dec_s;
    logic [IDX_W:0]        ld_dec_s;
    logic                  req_fire_s;
    logic                  ld_fire_s;
    logic                  ld_err_r;

    // Address decode, handshakes and the combinational array read from S1.
    always_comb begin
        req_dec_s  = addr_decode(req_addr);
        ld_dec_s   = addr_decode(ld_addr);
        s1_data_s  = s1_err_r ? {DATA_WIDTH{1'b0}} : mem_r[s1_idx_r];
        ld_ready   = !stages_busy_s;
        req_ready  = !ld_valid && (!s1_valid_r || s1_out_ok_s);
        req_fire_s = req_valid && req_ready;
        ld_fire_s  = ld_valid && ld_ready;
    end

    // Array write; a load can only fire with the pipeline empty, so no read sees it mid-flight.
    always_ff @(posedge clk) begin
        if (!reset && ld_fire_s && !ld_dec_s[IDX_W]) begin
            mem_r[ld_dec_s[IDX_W-1:0]] <= ld_data;
        end
    end

    // S1 address stage and the load error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_err_r   <= 1'b0;
            s1_idx_r   <= {IDX_W{1'b0}};
            ld_err_r   <= 1'b0;
        end else begin
            ld_err_r <= ld_fire_s && ld_dec_s[IDX_W];
            if (!s1_valid_r || s1_out_ok_s) begin
                s1_valid_r <= req_fire_s;
                if (req_fire_s) begin
                    s1_idx_r <= req_dec_s[IDX_W-1:0];
                    s1_err_r <= req_dec_s[IDX_W];
                end
            end
        end
    end

    assign ld_err = ld_err_r;

    if (OUT_REG != 0) begin : g_out_reg
        logic                  s2_valid_r;
        logic                  s2_err_r;
        logic [DATA_WIDTH-1:0] s2_data_r;
        logic                  s2_adv_s;

        // S2 drives the response; S1 may move whenever S2 can take it.
        always_comb begin
            s2_adv_s      = rsp_ready || !s2_valid_r;
            s1_out_ok_s   = s2_adv_s;
            stages_busy_s = s1_valid_r || s2_valid_r;
            rsp_valid     = s2_valid_r;
            rsp_data      = s2_data_r;
            rsp_err       = s2_err_r;
        end

        // Output data register stage.
        always_ff @(posedge clk) begin
            if (reset) begin
                s2_valid_r <= 1'b0;
                s2_err_r   <= 1'b0;
                s2_data_r  <= {DATA_WIDTH{1'b0}};
            end else if (s2_adv_s) begin
                s2_valid_r <= s1_valid_r;
                if (s1_valid_r) begin
                    s2_data_r <= s1_data_s;
                    s2_err_r  <= s1_err_r;
                end
            end
        end
    end else begin : g_no_out_reg
        // Response comes straight from S1 and the array read.
        always_comb begin
            s1_out_ok_s   = rsp_ready;
            stages_busy_s = s1_valid_r;
            rsp_valid     = s1_valid_r;
            rsp_data      = s1_data_s;
            rsp_err       = s1_err_r;
        end
    end
endmodule
